// File: rtl/step_counter_pkg.sv
// step_counter_pkg: shared types and constants for the step counter slice.
package step_counter_pkg;

    localparam int SYNC_STAGES = 2;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/tick_gen.sv
// tick_gen: prescaler counting 0..DIV-1, tick strobes for one cycle at DIV-1.
module tick_gen
    import step_counter_pkg::*;
#(
    parameter int DIV = 33554432
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int PW = $clog2(DIV);
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] cnt;

    generate
        if (DIV < 2) begin : g_bad_div
            $error("tick_gen: DIV must be at least 2");
        end
    endgenerate

    assign tick = cnt == LAST;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else
            cnt <= tick ? '0 : cnt + PW'(1);
    end

endmodule

// File: rtl/step_counter.sv
// step_counter: modulo up/down counter advanced by a synchronized button on each prescaler tick.
module step_counter
    import step_counter_pkg::*;
#(
    parameter int WIDTH  = 2,
    parameter int MODULO = 4,
    parameter int DIV    = 33554432
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             b,
    input  logic             dir,
    input  logic             clr,
    output logic [WIDTH-1:0] number,
    output logic             odd,
    output logic             tick,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULO - 1);

    logic [SYNC_STAGES-1:0] b_sync;
    logic                   b_s;
    logic                   step;
    logic                   at_top;
    logic                   at_zero;
    logic                   wrap_nxt;
    logic [WIDTH-1:0]       number_nxt;
    dir_e                   d;

    generate
        if (MODULO < 2 || MODULO > 2 ** WIDTH) begin : g_bad_modulo
            $error("step_counter: MODULO must lie in 2..2**WIDTH");
        end
    endgenerate

    tick_gen #(.DIV(DIV)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            b_sync <= '0;
        else
            b_sync <= {b_sync[SYNC_STAGES-2:0], b};
    end

    assign b_s = b_sync[SYNC_STAGES-1];
    assign d   = dir_e'(dir);

    // at_top uses >= so an out-of-range value still folds back to 0
    always_comb begin
        at_top     = number >= TOP;
        at_zero    = number == '0;
        step       = tick & b_s;
        number_nxt = (d == DIR_DOWN) ? (at_zero ? TOP : number - WIDTH'(1))
                                     : (at_top ? '0 : number + WIDTH'(1));
        wrap_nxt   = step & ((d == DIR_DOWN) ? at_zero : at_top);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            number <= '0;
            wrap   <= 1'b0;
        end else if (clr) begin
            number <= '0;
            wrap   <= 1'b0;
        end else begin
            if (step)
                number <= number_nxt;
            wrap <= wrap_nxt;
        end
    end

    assign odd = number[0];

endmodule

// File: tb/tb_step_counter.sv
// tb_step_counter: scoreboard bench driving a MODULO=4 and a MODULO=5 counter in lockstep.
module tb_step_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       b   = 1'b0;
    logic       dir = 1'b0;
    logic       clr = 1'b0;
    logic [1:0] n4;
    logic       odd4, tick4, wrap4;
    logic [2:0] n5;
    logic       odd5, tick5, wrap5;

    typedef struct packed {
        logic [1:0] n4;
        logic       w4;
        logic [2:0] n5;
        logic       w5;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   total = 0;
    int   bad   = 0;

    exp_t up_v [4] = '{
        '{2'd1, 1'b0, 3'd1, 1'b0},
        '{2'd2, 1'b0, 3'd2, 1'b0},
        '{2'd3, 1'b0, 3'd3, 1'b0},
        '{2'd0, 1'b1, 3'd4, 1'b0}
    };

    exp_t dn_v [5] = '{
        '{2'd3, 1'b1, 3'd4, 1'b1},
        '{2'd2, 1'b0, 3'd3, 1'b0},
        '{2'd1, 1'b0, 3'd2, 1'b0},
        '{2'd0, 1'b0, 3'd1, 1'b0},
        '{2'd3, 1'b1, 3'd0, 1'b0}
    };

    always #5 clk = ~clk;

    step_counter #(.WIDTH(2), .MODULO(4), .DIV(4)) u_dut4 (
        .clk    (clk),
        .rst    (rst),
        .b      (b),
        .dir    (dir),
        .clr    (clr),
        .number (n4),
        .odd    (odd4),
        .tick   (tick4),
        .wrap   (wrap4)
    );

    step_counter #(.WIDTH(3), .MODULO(5), .DIV(4)) u_dut5 (
        .clk    (clk),
        .rst    (rst),
        .b      (b),
        .dir    (dir),
        .clr    (clr),
        .number (n5),
        .odd    (odd5),
        .tick   (tick5),
        .wrap   (wrap5)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick4 && n < 10);
        if (!tick4)
            chk("tick_timeout", tick4, 1);
    endtask

    // Each tick edge may present a new count; compare it one negedge later.
    initial begin
        logic prev_tick;
        prev_tick = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_tick && q.size() > 0) begin
                e = q.pop_front();
                chk("n4", n4, e.n4);
                chk("wrap4", wrap4, e.w4);
                chk("odd4", odd4, e.n4[0]);
                chk("n5", n5, e.n5);
                chk("wrap5", wrap5, e.w5);
                chk("odd5", odd5, e.n5[0]);
                chk("tick5", tick5, 0);
            end
            prev_tick = tick4;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_n4", n4, 0);
        chk("rst_wrap4", wrap4, 0);
        chk("rst_tick4", tick4, 0);
        chk("rst_odd4", odd4, 0);
        chk("rst_n5", n5, 0);
        rst = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            chk("tick_period", tick4, (i % 4) == 3);
            chk("idle_n4", n4, 0);
        end
        b   = 1'b1;
        dir = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_tick(n);
            q.push_back(up_v[i]);
        end
        @(negedge clk);
        @(negedge clk);
        chk("wrap_one_cycle", wrap4, 0);
        clr = 1'b1;
        dir = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_n4", n4, 0);
        chk("clr_n5", n5, 0);
        for (int i = 0; i < 5; i++) begin
            wait_tick(n);
            q.push_back(dn_v[i]);
        end
        wait_tick(n);
        q.push_back('{2'd2, 1'b0, 3'd4, 1'b1});
        wait_tick(n);
        clr = 1'b1;
        q.push_back('{2'd0, 1'b0, 3'd0, 1'b0});
        @(negedge clk);
        clr = 1'b0;
        b   = 1'b0;
        wait_tick(n);
        chk("clr_tick_phase", n, 3);
        q.push_back('{2'd0, 1'b0, 3'd0, 1'b0});
        @(negedge clk);
        dir = 1'b0;
        @(negedge clk);
        b = 1'b1;
        @(negedge clk);
        b = 1'b0;
        wait_tick(n);
        chk("pulse_tick_gap", n, 1);
        q.push_back('{2'd1, 1'b0, 3'd1, 1'b0});
        @(negedge clk);
        b = 1'b1;
        @(negedge clk);
        b = 1'b0;
        wait_tick(n);
        q.push_back('{2'd1, 1'b0, 3'd1, 1'b0});
        @(negedge clk);
        b = 1'b1;
        wait_tick(n);
        q.push_back('{2'd2, 1'b0, 3'd2, 1'b0});
        wait_tick(n);
        q.push_back('{2'd3, 1'b0, 3'd3, 1'b0});
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_n4", n4, 3);
        rst = 1'b1;
        b   = 1'b0;
        #1;
        chk("async_rst_n4", n4, 0);
        chk("async_rst_wrap4", wrap4, 0);
        chk("async_rst_tick4", tick4, 0);
        chk("async_rst_n5", n5, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_wrap4", wrap4, 0);
            chk("post_rst_n4", n4, 0);
        end
        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
